// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the D-cache and I-cache clients.
// Requests and ready pass straight through; a read keeps the grant until its data returns.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrate between the two ports using the rr pointer
// S_HOLD    | request issued but not yet accepted; grant frozen on owner
// S_WAIT_RD | read accepted; waiting for i_mem_valid to route data back
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_INIT = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_d_ren,
    input  logic          i_d_wen,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_ready,
    output logic          o_d_valid,
    input  logic          i_i_ren,
    input  logic          i_i_wen,
    input  logic [AW-1:0] i_i_addr,
    input  logic [DW-1:0] i_i_wdata,
    output logic          o_i_ready,
    output logic          o_i_valid,
    output logic [DW-1:0] o_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_WAIT_RD = 2'd2
    } state_t;

    localparam logic L_RR_INIT = (PRIO_INIT != 0);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr;
    logic          w_rr_nxt;
    logic          r_owner;
    logic          w_owner_nxt;

    logic          w_d_req;
    logic          w_i_req;
    logic          w_win;
    logic          w_act;
    logic          w_acc;
    logic          w_wen;
    logic          w_ren;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_d_valid;
    logic          w_i_valid;

    assign w_d_req = i_d_ren | i_d_wen;
    assign w_i_req = i_i_ren | i_i_wen;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rr    <= L_RR_INIT;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // w_win: 0 selects the D port, 1 selects the I port
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_win       = r_owner;
        w_act       = 1'b0;
        w_d_valid   = 1'b0;
        w_i_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_act = w_d_req | w_i_req;
                w_win = (w_d_req && w_i_req) ? r_rr : w_i_req;
            end
            S_HOLD: begin
                w_win = r_owner;
                w_act = r_owner ? w_i_req : w_d_req;
                if (!w_act) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_RD: begin
                if (i_mem_valid) begin
                    w_d_valid   = ~r_owner;
                    w_i_valid   = r_owner;
                    w_rr_nxt    = ~r_owner;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A port raising ren and wen together is treated as a write.
        w_wen   = w_act & (w_win ? i_i_wen : i_d_wen);
        w_ren   = w_act & ~w_wen & (w_win ? i_i_ren : i_d_ren);
        w_addr  = w_act ? (w_win ? i_i_addr : i_d_addr) : '0;
        w_wdata = w_act ? (w_win ? i_i_wdata : i_d_wdata) : '0;
        w_acc   = w_act & i_mem_ready;

        if (w_act) begin
            if (w_acc && w_wen) begin
                w_rr_nxt    = ~w_win;
                w_state_nxt = S_IDLE;
            end else if (w_acc) begin
                w_owner_nxt = w_win;
                w_state_nxt = S_WAIT_RD;
            end else begin
                w_owner_nxt = w_win;
                w_state_nxt = S_HOLD;
            end
        end
    end

    // Outputs are forced low while reset is held, including the pass-through paths.
    assign o_mem_ren   = i_rst_n & w_ren;
    assign o_mem_wen   = i_rst_n & w_wen;
    assign o_mem_addr  = {AW{i_rst_n}} & w_addr;
    assign o_mem_wdata = {DW{i_rst_n}} & w_wdata;
    assign o_d_ready   = i_rst_n & w_acc & ~w_win;
    assign o_i_ready   = i_rst_n & w_acc & w_win;
    assign o_d_valid   = i_rst_n & w_d_valid;
    assign o_i_valid   = i_rst_n & w_i_valid;
    assign o_rdata     = {DW{i_rst_n}} & i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_ren, d_wen, i_ren, i_wen;
    logic [31:0] d_addr, d_wdata, i_addr, i_wdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;

    logic        o_d_ready, o_d_valid, o_i_ready, o_i_valid;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(32), .DW(32), .PRIO_INIT(0)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_d_ren    (d_ren),
        .i_d_wen    (d_wen),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_ready  (o_d_ready),
        .o_d_valid  (o_d_valid),
        .i_i_ren    (i_ren),
        .i_i_wen    (i_wen),
        .i_i_addr   (i_addr),
        .i_i_wdata  (i_wdata),
        .o_i_ready  (o_i_ready),
        .o_i_valid  (o_i_valid),
        .o_rdata    (o_rdata),
        .o_mem_addr (o_mem_addr),
        .o_mem_ren  (o_mem_ren),
        .o_mem_wen  (o_mem_wen),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(mem_ready),
        .i_mem_rdata(mem_rdata),
        .i_mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
        i_ren = 0; i_wen = 0; i_addr = 0; i_wdata = 0;
        mem_ready = 0; mem_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        logic [101:0] outs;
        rst_n = 0;
        d_ren = 1; d_wen = 0; d_addr = 32'h1234; d_wdata = 32'h55;
        i_ren = 1; i_wen = 1; i_addr = 32'h777; i_wdata = 32'h99;
        mem_ready = 1; mem_valid = 1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        outs = {o_d_ready, o_d_valid, o_i_ready, o_i_valid, o_rdata,
                o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        clear_inputs();
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_single_read();
        int rdy_cnt, dv_cnt, iv_cnt;
        logic [31:0] got;
        rdy_cnt = 0; dv_cnt = 0; iv_cnt = 0; got = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            d_ren = (c == 0); d_addr = 32'h100; mem_ready = 1;
            mem_valid = (c == 3);
            mem_rdata = (c == 3) ? 32'hCAFEF00D : 32'h0;
            @(negedge clk);
            if (c == 0) begin
                total++;
                if ({o_mem_ren, o_mem_wen, o_mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
                    bad++;
                    $display("FAIL read_request got ren=%b wen=%b addr=%h want 1 0 00000100",
                             o_mem_ren, o_mem_wen, o_mem_addr);
                end
            end
            rdy_cnt += int'(o_d_ready);
            dv_cnt  += int'(o_d_valid);
            iv_cnt  += int'(o_i_valid);
            if (o_d_valid) got = o_rdata;
        end
        total++;
        if (rdy_cnt != 1) begin bad++; $display("FAIL read_ready_pulses got=%0d want=1", rdy_cnt); end
        total++;
        if (dv_cnt != 1) begin bad++; $display("FAIL read_d_valid_pulses got=%0d want=1", dv_cnt); end
        total++;
        if (iv_cnt != 0) begin bad++; $display("FAIL read_i_valid_pulses got=%0d want=0", iv_cnt); end
        total++;
        if (got !== 32'hCAFEF00D) begin bad++; $display("FAIL read_data got=%h want=cafef00d", got); end
        clear_inputs();
    endtask

    task automatic test_both_read();
        int n, vcnt, vbad, both;
        logic [3:0] order;
        bit pend, last;
        n = 0; vcnt = 0; vbad = 0; both = 0; order = 0; pend = 0; last = 0;
        do_reset();
        for (int c = 0; c < 40 && vcnt < 4; c++) begin
            @(posedge clk); #1;
            d_ren = 1; i_ren = 1; mem_ready = 1;
            d_addr = 32'hD00 + c; i_addr = 32'h100 + c;
            mem_valid = pend; mem_rdata = $urandom; pend = 0;
            @(negedge clk);
            if (o_d_ready && o_i_ready) both++;
            if (o_d_valid || o_i_valid) begin
                vcnt++;
                if (o_i_valid !== last || o_d_valid === o_i_valid) vbad++;
            end
            if (o_d_ready || o_i_ready) begin
                if (n < 4) order[n] = o_i_ready;
                last = o_i_ready;
                n++;
                pend = 1;
            end
        end
        total++;
        if (n != 4 || order !== 4'b1010) begin
            bad++;
            $display("FAIL alternate_order got n=%0d order=%b want n=4 order=1010", n, order);
        end
        total++;
        if (vcnt != 4 || vbad != 0) begin
            bad++;
            $display("FAIL alternate_valid_routing got valids=%0d misrouted=%0d want 4 0", vcnt, vbad);
        end
        total++;
        if (both != 0) begin bad++; $display("FAIL alternate_double_grant got=%0d want=0", both); end
        clear_inputs();
    endtask

    task automatic test_hold();
        bit dacc;
        dacc = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            i_ren = (c <= 5); i_addr = 32'h200;
            d_wen = (c >= 2) && !dacc; d_addr = 32'h300; d_wdata = 32'h5A5A;
            mem_ready = (c >= 5); mem_valid = (c == 8); mem_rdata = 32'h1111;
            @(negedge clk);
            if (c < 5) begin
                total++;
                if ({o_mem_addr, o_d_ready, o_i_ready} !== {32'h200, 2'b00}) begin
                    bad++;
                    $display("FAIL hold_frozen c=%0d got addr=%h dr=%b ir=%b want 00000200 0 0",
                             c, o_mem_addr, o_d_ready, o_i_ready);
                end
            end
            if (c == 5) begin
                total++;
                if ({o_i_ready, o_mem_ren, o_d_ready, o_mem_addr} !== {3'b110, 32'h200}) begin
                    bad++;
                    $display("FAIL hold_accept got ir=%b ren=%b dr=%b addr=%h want 1 1 0 00000200",
                             o_i_ready, o_mem_ren, o_d_ready, o_mem_addr);
                end
            end
            if (c == 6 || c == 7) begin
                total++;
                if ({o_d_ready, o_mem_wen, o_mem_ren} !== 3'b000) begin
                    bad++;
                    $display("FAIL hold_wait_blocked c=%0d got dr=%b wen=%b ren=%b want 0 0 0",
                             c, o_d_ready, o_mem_wen, o_mem_ren);
                end
            end
            if (c == 8) begin
                total++;
                if ({o_i_valid, o_d_valid, o_d_ready} !== 3'b100) begin
                    bad++;
                    $display("FAIL hold_i_valid got iv=%b dv=%b dr=%b want 1 0 0",
                             o_i_valid, o_d_valid, o_d_ready);
                end
            end
            if (c == 9) begin
                total++;
                if ({o_d_ready, o_mem_wen, o_mem_addr, o_mem_wdata} !== {2'b11, 32'h300, 32'h5A5A}) begin
                    bad++;
                    $display("FAIL hold_d_after got dr=%b wen=%b addr=%h wdata=%h want 1 1 00000300 00005a5a",
                             o_d_ready, o_mem_wen, o_mem_addr, o_mem_wdata);
                end
            end
            if (o_d_ready) dacc = 1;
        end
        clear_inputs();
    endtask

    task automatic test_burst();
        logic [5:0] mask;
        int wcnt;
        mask = 0; wcnt = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            d_wen = (k < 4); d_addr = 32'h40 + k; d_wdata = 32'h1000 + k; mem_ready = 1;
            @(negedge clk);
            mask[k] = o_d_ready;
            wcnt += int'(o_mem_wen);
            if (o_d_ready) begin
                total++;
                if ({o_mem_addr, o_mem_wdata} !== {32'h40 + k, 32'h1000 + k}) begin
                    bad++;
                    $display("FAIL burst_data k=%0d got addr=%h wdata=%h", k, o_mem_addr, o_mem_wdata);
                end
            end
        end
        total++;
        if (mask !== 6'b001111) begin bad++; $display("FAIL burst_accepts got=%b want=001111", mask); end
        total++;
        if (wcnt != 4) begin bad++; $display("FAIL burst_wen_cycles got=%0d want=4", wcnt); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [101:0] outs;
        do_reset();
        @(posedge clk); #1;
        d_wen = 1; d_addr = 32'h10; mem_ready = 1;
        @(posedge clk); #1;
        d_wen = 0; i_ren = 1; i_addr = 32'h20;
        @(posedge clk); #1;
        i_ren = 0; d_ren = 1; rst_n = 0; mem_valid = 1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        outs = {o_d_ready, o_d_valid, o_i_ready, o_i_valid, o_rdata,
                o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", outs); end
        @(posedge clk); #1;
        rst_n = 1; d_ren = 0; mem_valid = 1; mem_rdata = 32'hBEEF;
        @(negedge clk);
        total++;
        if ({o_d_valid, o_i_valid} !== 2'b00) begin
            bad++;
            $display("FAIL late_valid_dropped got dv=%b iv=%b want 0 0", o_d_valid, o_i_valid);
        end
        @(posedge clk); #1;
        mem_valid = 0; d_ren = 1; i_ren = 1; d_addr = 32'hA0; i_addr = 32'hB0;
        @(negedge clk);
        total++;
        if ({o_d_ready, o_i_ready, o_mem_addr} !== {2'b10, 32'hA0}) begin
            bad++;
            $display("FAIL midreset_rr got dr=%b ir=%b addr=%h want 1 0 000000a0",
                     o_d_ready, o_i_ready, o_mem_addr);
        end
        clear_inputs();
    endtask

    task automatic test_rw_both();
        int dv;
        dv = 0;
        do_reset();
        @(posedge clk); #1;
        d_ren = 1; d_wen = 1; d_addr = 32'h55; d_wdata = 32'h66; mem_ready = 1;
        @(negedge clk);
        total++;
        if ({o_mem_wen, o_mem_ren, o_d_ready} !== 3'b101) begin
            bad++;
            $display("FAIL rw_as_write got wen=%b ren=%b dr=%b want 1 0 1", o_mem_wen, o_mem_ren, o_d_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            d_ren = 0; d_wen = 0; mem_valid = 1; mem_rdata = 32'h77;
            @(negedge clk);
            dv += int'(o_d_valid);
        end
        total++;
        if (dv != 0) begin bad++; $display("FAIL rw_no_valid got=%0d want=0", dv); end
        clear_inputs();
    endtask

    // Reference: one transaction at a time; a pending request keeps its grant;
    // the port not served last is preferred when both ask.
    task automatic test_random(input int ncyc);
        bit          m_wait, m_pref;
        int          m_wport, m_hold, lat, port, op;
        bit          act;
        bit          acc[2];
        logic        rq_r[2], rq_w[2];
        logic [31:0] rq_a[2], rq_d[2];
        logic        e_ren, e_wen, e_dr, e_ir, e_dv, e_iv;
        logic [31:0] e_addr, e_wdata;
        logic [101:0] exp_v, got_v;

        m_wait = 0; m_pref = 0; m_wport = 0; m_hold = -1; lat = 0;
        for (int p = 0; p < 2; p++) begin
            rq_r[p] = 0; rq_w[p] = 0; rq_a[p] = 0; rq_d[p] = 0;
        end
        do_reset();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            d_ren = rq_r[0]; d_wen = rq_w[0]; d_addr = rq_a[0]; d_wdata = rq_d[0];
            i_ren = rq_r[1]; i_wen = rq_w[1]; i_addr = rq_a[1]; i_wdata = rq_d[1];
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            if (m_wait) begin
                if (lat == 0) mem_valid = 1;
                else begin mem_valid = 0; lat--; end
            end else begin
                mem_valid = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);

            e_ren = 0; e_wen = 0; e_dr = 0; e_ir = 0; e_dv = 0; e_iv = 0;
            e_addr = 0; e_wdata = 0; acc[0] = 0; acc[1] = 0; act = 0; port = 0;
            if (m_wait) begin
                if (mem_valid) begin
                    if (m_wport == 0) e_dv = 1; else e_iv = 1;
                    m_pref = (m_wport == 0);
                    m_wait = 0;
                end
            end else begin
                if (m_hold >= 0) begin
                    port = m_hold;
                    act = rq_r[port] | rq_w[port];
                    m_hold = -1;
                end else if ((rq_r[0] | rq_w[0]) && (rq_r[1] | rq_w[1])) begin
                    port = int'(m_pref); act = 1;
                end else if (rq_r[1] | rq_w[1]) begin
                    port = 1; act = 1;
                end else if (rq_r[0] | rq_w[0]) begin
                    port = 0; act = 1;
                end
                if (act) begin
                    e_wen = rq_w[port];
                    e_ren = rq_r[port] & ~rq_w[port];
                    e_addr = rq_a[port];
                    e_wdata = rq_d[port];
                    if (mem_ready) begin
                        acc[port] = 1;
                        if (port == 0) e_dr = 1; else e_ir = 1;
                        if (e_wen) m_pref = (port == 0);
                        else begin
                            m_wait = 1; m_wport = port; lat = $urandom_range(0, 3);
                        end
                    end else begin
                        m_hold = port;
                    end
                end
            end

            exp_v = {e_dr, e_dv, e_ir, e_iv, mem_rdata, e_addr, e_ren, e_wen, e_wdata};
            got_v = {o_d_ready, o_d_valid, o_i_ready, o_i_valid, o_rdata,
                     o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            end

            for (int p = 0; p < 2; p++) begin
                if (acc[p] || !(rq_r[p] | rq_w[p])) begin
                    if ($urandom_range(0, 2) == 0) begin
                        op = $urandom_range(0, 3);
                        rq_r[p] = (op != 1);
                        rq_w[p] = (op == 1 || op == 2);
                        rq_a[p] = $urandom;
                        rq_d[p] = $urandom;
                    end else begin
                        rq_r[p] = 0; rq_w[p] = 0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rq_r[p] = 0; rq_w[p] = 0;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_both_read();
        test_hold();
        test_burst();
        test_reset_mid();
        test_rw_both();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
